// File: rtl/ifu_fetch_buf.sv
// Instruction fetch unit with in-order response buffer feeding IDU0.
// Define IFU_EXIT_HALT_EN to stop fetching after an eBPF exit (opcode 0x95) is buffered.
module ifu_fetch_buf #(
    parameter int unsigned          FIFO_DEPTH = 4,
    parameter int unsigned          XLEN       = 64,
    parameter int unsigned          INSTR_LEN  = 64,
    parameter logic [XLEN-1:0]      RESET_PC   = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    output logic                    imem_req_valid,
    output logic [XLEN-1:0]         imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_rsp_valid,
    input  logic [INSTR_LEN-1:0]    imem_rsp_data,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    input  logic                    pipe_stall,
    output logic [INSTR_LEN-1:0]    instr,
    output logic                    instr_valid,
    output logic [XLEN-1:0]         instr_tag
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [XLEN-1:0]        fetch_pc;
    logic [XLEN-1:0]        rsp_pc;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          discard;
    logic [CW-1:0]          fifo_count;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [INSTR_LEN-1:0]   mem_data [FIFO_DEPTH];
    logic [XLEN-1:0]        mem_tag  [FIFO_DEPTH];
    logic                   credit_ok;
    logic                   req_fire;
    logic                   push;
    logic                   pop;
    logic                   exit_push;

    // Buffered entries plus outstanding requests must never exceed the buffer size.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH);
    assign req_fire  = imem_req_valid & imem_req_ready;
    assign push      = imem_rsp_valid & ~redirect_valid & (discard == '0);
    assign pop       = instr_valid & ~pipe_stall;

`ifdef IFU_EXIT_HALT_EN
    assign exit_push = push & (state == FETCH) & (imem_rsp_data[7:0] == 8'h95);
`else
    assign exit_push = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (exit_push) state_next = HALTED;
            HALTED:  if (redirect_valid) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = (state == FETCH) & ~redirect_valid & credit_ok;
    end

    assign imem_req_addr = fetch_pc;
    assign instr_valid   = (fifo_count != '0);
    assign instr         = mem_data[rd_ptr];
    assign instr_tag     = mem_tag[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(8);
                if (push)     rsp_pc   <= rsp_pc + XLEN'(8);
            end
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            // Everything still outstanding after a redirect or exit belongs to the abandoned path.
            if (redirect_valid)
                discard <= inflight - CW'(imem_rsp_valid);
            else if (exit_push)
                discard <= inflight + CW'(req_fire) - CW'(1);
            else if (imem_rsp_valid && (discard != '0))
                discard <= discard - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_tag[i]  <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= imem_rsp_data;
                mem_tag[wr_ptr]  <= rsp_pc;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Scoreboard bench for ifu_fetch_buf: a latency-configurable memory model feeds the DUT,
// directed scenarios queue expected (tag, instr) pairs and a monitor checks every pop.
module tb_ifu_fetch_buf;

    typedef struct {
        logic [63:0] tag;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [63:0] addr;
    } pend_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [63:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        pipe_stall;
    logic [63:0] instr;
    logic        instr_valid;
    logic [63:0] instr_tag;

    int    total = 0;
    int    bad   = 0;
    int    cyc_n = 0;
    int    lat   = 1;
    int    fires;
    exp_t  exp_q[$];
    pend_t pend[$];
    logic [63:0] exit_addr = '1;
    logic        s_reqv, s_ivalid, s_fire;
    logic [63:0] s_addr;

    ifu_fetch_buf #(.FIFO_DEPTH(4), .XLEN(64), .INSTR_LEN(64), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pipe_stall     (pipe_stall),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_tag      (instr_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] memf(input logic [63:0] a);
        memf = {~a[55:0], (a == exit_addr) ? 8'h95 : 8'hB7};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic expect_seq(input logic [63:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.tag  = start + 64'(8 * i);
            e.data = memf(e.tag);
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample DUT just after the input-change point, then present the memory response.
    task automatic cyc();
        #1;
        s_reqv   = imem_req_valid;
        s_addr   = imem_req_addr;
        s_ivalid = instr_valid;
        s_fire   = imem_req_valid && imem_req_ready;
        if (s_fire) pend.push_back('{cyc_n + lat, imem_req_addr});
        @(negedge clk);
        cyc_n++;
        redirect_valid = 1'b0;
        if (pend.size() != 0 && pend[0].due <= cyc_n) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic drain(input string nm, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            cyc();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d entries never delivered, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic redirect(input logic [63:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
    endtask

    always begin
        @(negedge clk);
        #1;
        if (rstn && instr_valid && !pipe_stall && !redirect_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pop: got tag %h, required no output", instr_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (instr_tag !== e.tag) begin
                    bad++;
                    $display("FAIL pop_tag: got %h, required %h", instr_tag, e.tag);
                end
                total++;
                if (instr !== e.data) begin
                    bad++;
                    $display("FAIL pop_instr: got %h, required %h", instr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; pipe_stall = 1'b0;
        #2 rstn = 1'b0;
        @(negedge clk);

        // Reset and streaming
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rst_ivalid", 64'(s_ivalid), 64'd0);
            chk("rst_reqv", 64'(s_reqv), 64'd0);
            chk("rst_addr", s_addr, 64'h0);
        end
        chk("rst_instr", instr, 64'h0);
        chk("rst_tag", instr_tag, 64'h0);
        expect_seq(64'h0, 3);
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("stream_reqv", 64'(s_reqv), 64'(k >= 1));
            chk("stream_ivalid", 64'(s_ivalid), 64'(k >= 3));
            if (k == 1) chk("first_req_addr", s_addr, 64'h0);
        end
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Back-pressure
        pipe_stall = 1'b1;
        fires = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            fires += int'(s_fire);
        end
        chk("stall_fires", 64'(fires), 64'd2);
        chk("stall_reqv", 64'(s_reqv), 64'd0);
        chk("stall_addr", s_addr, 64'h38);
        expect_seq(64'h18, 6);
        pipe_stall = 1'b0;
        drain("drain_backpressure", 60);
        pipe_stall = 1'b1;

        // Redirect with three responses outstanding
        repeat (4) cyc();
        lat = 4;
        redirect(64'h80);
        cyc();
        repeat (3) cyc();
        expect_seq(64'h100, 3);
        redirect(64'h100);
        pipe_stall = 1'b0;
        cyc();
        chk("redir_no_req", 64'(s_reqv), 64'd0);
        cyc();
        chk("redir_ivalid_after", 64'(s_ivalid), 64'd0);
        chk("redir_req_addr", s_addr, 64'h100);
        drain("drain_redirect", 80);
        pipe_stall = 1'b1;

        // Redirect coinciding with a response and ready
        repeat (12) cyc();
        lat = 1;
        redirect(64'h200);
        cyc();
        cyc();
        expect_seq(64'h300, 3);
        redirect(64'h300);
        cyc();
        chk("sim_no_req", 64'(s_reqv), 64'd0);
        cyc();
        chk("sim_reqv", 64'(s_reqv), 64'd1);
        chk("sim_next_addr", s_addr, 64'h300);
        chk("sim_ivalid", 64'(s_ivalid), 64'd0);
        pipe_stall = 1'b0;
        drain("drain_simultaneous", 60);
        pipe_stall = 1'b1;

        // Exit instruction at 0x18, with a not-ready window on the first request
        repeat (6) cyc();
        exit_addr = 64'h18;
        imem_req_ready = 1'b0;
        redirect(64'h0);
        cyc();
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("hold_reqv", 64'(s_reqv), 64'd1);
            chk("hold_addr", s_addr, 64'h0);
        end
        imem_req_ready = 1'b1;
`ifdef IFU_EXIT_HALT_EN
        expect_seq(64'h0, 4);
        pipe_stall = 1'b0;
        drain("drain_exit", 60);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("halt_reqv", 64'(s_reqv), 64'd0);
            chk("halt_ivalid", 64'(s_ivalid), 64'd0);
        end
        exit_addr = '1;
        expect_seq(64'h500, 2);
        redirect(64'h500);
        drain("drain_resume", 60);
`else
        expect_seq(64'h0, 5);
        pipe_stall = 1'b0;
        drain("drain_exit_passthrough", 60);
        exit_addr = '1;
`endif
        pipe_stall = 1'b1;

        // Mid-stream asynchronous reset, then PC wrap
        repeat (3) cyc();
        chk("pre_reset_ivalid", 64'(s_ivalid), 64'd1);
        #3 rstn = 1'b0;
        #1;
        chk("mrst_ivalid", 64'(instr_valid), 64'd0);
        chk("mrst_instr", instr, 64'h0);
        chk("mrst_tag", instr_tag, 64'h0);
        chk("mrst_reqv", 64'(imem_req_valid), 64'd0);
        chk("mrst_addr", imem_req_addr, 64'h0);
        pend.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        @(negedge clk);
        repeat (2) cyc();
        rstn = 1'b1;
        repeat (3) cyc();
        expect_seq(64'hFFFF_FFFF_FFFF_FFF8, 3);
        redirect(64'hFFFF_FFFF_FFFF_FFF8);
        pipe_stall = 1'b0;
        cyc();
        drain("drain_wrap", 60);
        pipe_stall = 1'b1;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
